// File: rtl/explosion_scheduler.sv
// explosion_scheduler
//   Queues explosion events from the bomb block and, for each one, paints a
//   cross of FLAME tiles into the shared tile map. Each arm reaches up to
//   RANGE tiles. Walls stop an arm, soft blocks are burnt and then stop it,
//   and tiles outside the map end the arm without any map access.
//
//   Optional build macro: CHAIN_REACTION_EN. When defined, a BOMB tile found
//   by an arm is queued as a new explosion event. When undefined, a BOMB
//   tile behaves exactly like a WALL.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   ev_valid/ev_ready      event handshake (accepted when both are high)
//   ev_x, ev_y             tile-aligned pixel coordinates (tile = [9:4])
//   map_req/map_gnt        tile-map request/grant; access happens on req&gnt
//   map_addr               tile address ty*MAP_COLS+tx
//   map_we, map_wdata      write enable and tile code to write
//   map_rdata              read data, valid the cycle after a granted read
//   busy                   FSM active or events still queued
//   flame_done             one-cycle pulse per completed event
//   overflow               sticky, set when an event is dropped
module explosion_scheduler #(
  parameter int MAP_COLS   = 40,
  parameter int MAP_ROWS   = 30,
  parameter int RANGE      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ev_valid,
  input  logic [9:0]  ev_x,
  input  logic [9:0]  ev_y,
  output logic        ev_ready,
  output logic        map_req,
  input  logic        map_gnt,
  output logic [10:0] map_addr,
  output logic        map_we,
  output logic [2:0]  map_wdata,
  input  logic [2:0]  map_rdata,
  output logic        busy,
  output logic        flame_done,
  output logic        overflow
);

  // state  | meaning
  // IDLE   | nothing queued, map port quiet
  // POP    | dequeue an event, latch its tile, bounds-check the centre
  // CWR    | write FLAME to the centre tile
  // RD     | read the current arm/step tile
  // WAIT   | read data valid, decide write / stop arm
  // WR     | write FLAME to the current arm/step tile
  // DONE   | pulse flame_done, fetch next event or go idle
  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_CWR, S_RD, S_WAIT, S_WR, S_DONE
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] T_EMPTY = 3'd0;
  localparam logic [2:0] T_SOFT  = 3'd2;
  localparam logic [2:0] T_BOMB  = 3'd3;
  localparam logic [2:0] T_FLAME = 3'd4;

  localparam logic signed [6:0] COLS_S  = 7'(MAP_COLS);
  localparam logic signed [6:0] ROWS_S  = 7'(MAP_ROWS);
  localparam logic [6:0]        COLS_U  = 7'(MAP_COLS);
  localparam logic [6:0]        ROWS_U  = 7'(MAP_ROWS);
  localparam logic [10:0]       COLS_11 = 11'(MAP_COLS);
  localparam logic [2:0]        RANGE_3 = 3'(RANGE);

  // Arm encoding: 0 = R (+x), 1 = L (-x), 2 = D (+y), 3 = U (-y).
  // Seven signed bits leave room for both underflow and tx + RANGE.
  function automatic logic signed [6:0] arm_x(input logic [1:0] arm,
                                              input logic [3:0] step,
                                              input logic [5:0] tx);
    logic signed [6:0] b, s;
    b = $signed({1'b0, tx});
    s = $signed({3'b000, step});
    case (arm)
      2'd0:    arm_x = b + s;
      2'd1:    arm_x = b - s;
      default: arm_x = b;
    endcase
  endfunction

  function automatic logic signed [6:0] arm_y(input logic [1:0] arm,
                                              input logic [3:0] step,
                                              input logic [5:0] ty);
    logic signed [6:0] b, s;
    b = $signed({1'b0, ty});
    s = $signed({3'b000, step});
    case (arm)
      2'd2:    arm_y = b + s;
      2'd3:    arm_y = b - s;
      default: arm_y = b;
    endcase
  endfunction

  function automatic logic in_map(input logic signed [6:0] x,
                                  input logic signed [6:0] y);
    in_map = (x >= 7'sd0) && (x < COLS_S) && (y >= 7'sd0) && (y < ROWS_S);
  endfunction

  state_t             state_q, state_d;
  logic [5:0]         tx_q, tx_d, ty_q, ty_d;
  logic [1:0]         arm_q, arm_d;
  logic [2:0]         step_q, step_d;
  logic               end_arm_q, end_arm_d;
  logic               overflow_q, overflow_d;

  logic [11:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               full, ext_push, chain_push, chain_ok, pop;
  logic [11:0]        head, ext_entry, chain_entry;
  logic [PTR_W-1:0]   chain_ptr;

  logic signed [6:0]  cur_x, cur_y, nx_x, nx_y;
  logic [10:0]        cur_addr;
  logic [3:0]         inb1;
  logic               cand_ok, found;
  logic [1:0]         nxt_arm;
  logic               adv_req, adv_cont;
  logic               unused_bits;

  assign unused_bits = ^{ev_x[3:0], ev_y[3:0], cur_x[6], cur_y[6]};

  // FIFO status and pushes
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign ext_push    = ev_valid && !full;
  assign ext_entry   = {ev_x[9:4], ev_y[9:4]};
  assign chain_entry = {cur_x[5:0], cur_y[5:0]};
  // External pushes win the last free slot.
  assign chain_ok    = chain_push && !full &&
                       !(ext_push && (count_q == CNT_W'(FIFO_DEPTH - 1)));
  assign chain_ptr   = wr_ptr_q + PTR_W'(ext_push);
  assign head        = mem_q[rd_ptr_q];

  // Current tile (step 0 is the centre) and its map address
  assign cur_x    = arm_x(arm_q, {1'b0, step_q}, tx_q);
  assign cur_y    = arm_y(arm_q, {1'b0, step_q}, ty_q);
  assign cur_addr = ({5'b0, cur_y[5:0]} * COLS_11) + {5'b0, cur_x[5:0]};

  // Next position: either the next step of this arm, or step 1 of the
  // first later arm that starts inside the map. Out-of-map steps are
  // skipped here so they cost no cycles.
  always_comb begin
    inb1    = '0;
    found   = 1'b0;
    nxt_arm = arm_q;
    nx_x    = arm_x(arm_q, {1'b0, step_q} + 4'd1, tx_q);
    nx_y    = arm_y(arm_q, {1'b0, step_q} + 4'd1, ty_q);
    cand_ok = (step_q < RANGE_3) && in_map(nx_x, nx_y);
    for (int a = 0; a < 4; a++) begin
      inb1[a] = in_map(arm_x(2'(a), 4'd1, tx_q), arm_y(2'(a), 4'd1, ty_q));
    end
    for (int a = 1; a < 4; a++) begin
      if (!found && (2'(a) > arm_q) && inb1[a]) begin
        found   = 1'b1;
        nxt_arm = 2'(a);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    arm_d      = arm_q;
    step_d     = step_q;
    end_arm_d  = end_arm_q;
    pop        = 1'b0;
    chain_push = 1'b0;
    adv_req    = 1'b0;
    adv_cont   = 1'b0;

    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_POP;
      S_POP: begin
        pop       = 1'b1;
        tx_d      = head[11:6];
        ty_d      = head[5:0];
        arm_d     = 2'd0;
        step_d    = 3'd0;
        end_arm_d = 1'b0;
        if (({1'b0, head[11:6]} >= COLS_U) || ({1'b0, head[5:0]} >= ROWS_U))
          state_d = S_DONE;
        else
          state_d = S_CWR;
      end
      S_CWR: begin
        adv_req  = map_gnt;
        adv_cont = 1'b1;
      end
      S_RD: if (map_gnt) state_d = S_WAIT;
      S_WAIT: begin
        case (map_rdata)
          T_EMPTY, T_FLAME: begin
            end_arm_d = 1'b0;
            state_d   = S_WR;
          end
          T_SOFT: begin
            end_arm_d = 1'b1;
            state_d   = S_WR;
          end
          T_BOMB: begin
`ifdef CHAIN_REACTION_EN
            chain_push = 1'b1;
`endif
            adv_req = 1'b1;
          end
          default: adv_req = 1'b1;
        endcase
      end
      S_WR: begin
        adv_req  = map_gnt;
        adv_cont = !end_arm_q;
      end
      S_DONE: state_d = (count_q != '0) ? S_POP : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (adv_req) begin
      if (adv_cont && cand_ok) begin
        step_d  = step_q + 3'd1;
        state_d = S_RD;
      end else if (found) begin
        arm_d   = nxt_arm;
        step_d  = 3'd1;
        state_d = S_RD;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  assign overflow_d = overflow_q || (ev_valid && full) || (chain_push && !chain_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      ty_q       <= '0;
      arm_q      <= '0;
      step_q     <= '0;
      end_arm_q  <= 1'b0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      arm_q      <= arm_d;
      step_q     <= step_d;
      end_arm_q  <= end_arm_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
      wr_ptr_q   <= wr_ptr_q + PTR_W'(ext_push) + PTR_W'(chain_ok);
      count_q    <= count_q + CNT_W'(ext_push) + CNT_W'(chain_ok) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (ext_push) mem_q[wr_ptr_q] <= ext_entry;
    if (chain_ok) mem_q[chain_ptr] <= chain_entry;
  end

  // Map port is a pure decode of registered state, so it holds steady
  // from request until grant.
  assign map_req    = (state_q == S_CWR) || (state_q == S_RD) || (state_q == S_WR);
  assign map_we     = (state_q == S_CWR) || (state_q == S_WR);
  assign map_addr   = map_req ? cur_addr : 11'd0;
  assign map_wdata  = map_we ? T_FLAME : 3'd0;

  assign ev_ready   = !full;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign flame_done = (state_q == S_DONE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_explosion_scheduler.sv
module tb_explosion_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ev_valid = 1'b0;
  logic [9:0]  ev_x = '0;
  logic [9:0]  ev_y = '0;
  logic        ev_ready;
  logic        map_req;
  logic        map_gnt = 1'b1;
  logic [10:0] map_addr;
  logic        map_we;
  logic [2:0]  map_wdata;
  logic [2:0]  map_rdata = 3'd7;
  logic        busy;
  logic        flame_done;
  logic        overflow;

  explosion_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .ev_valid   (ev_valid),
    .ev_x       (ev_x),
    .ev_y       (ev_y),
    .ev_ready   (ev_ready),
    .map_req    (map_req),
    .map_gnt    (map_gnt),
    .map_addr   (map_addr),
    .map_we     (map_we),
    .map_wdata  (map_wdata),
    .map_rdata  (map_rdata),
    .busy       (busy),
    .flame_done (flame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  tmap [0:1199];
  logic [11:0] exp_acc [$];   // {we, addr}
  int          exp_done [$];  // cycle number of the flame_done pulse
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic acc(input bit we, input int a);
    exp_acc.push_back({we, 11'(a)});
  endtask

  task automatic arm2(input int a1, input int a2);
    acc(1'b0, a1); acc(1'b1, a1); acc(1'b0, a2); acc(1'b1, a2);
  endtask

  task automatic cross_160();
    acc(1'b1, 410);
    arm2(411, 412); arm2(409, 408); arm2(450, 490); arm2(370, 330);
  endtask

  task automatic clear_map();
    for (int i = 0; i < 1200; i++) tmap[i] = 3'd0;
  endtask

  // Monitor and map RAM model: checks every granted access and every
  // flame_done pulse against the scoreboard queues.
  task automatic run_monitor();
    logic [11:0] e;
    logic [2:0]  rd_val;
    bit          rd_hit;
    int          d;
    rd_val = 3'd0;
    forever begin
      @(negedge clk);
      rd_hit = 1'b0;
      if (map_req && map_gnt) begin
        check("acc_expected", int'(exp_acc.size() != 0), 1);
        if (exp_acc.size() != 0) begin
          e = exp_acc.pop_front();
          check("acc_we", int'(map_we), int'(e[11]));
          check("acc_addr", int'(map_addr), int'(e[10:0]));
        end
        if (map_we) begin
          check("acc_wdata", int'(map_wdata), 4);
          if (map_addr < 11'd1200) tmap[map_addr] = map_wdata;
        end else if (map_addr < 11'd1200) begin
          rd_val = tmap[map_addr];
          rd_hit = 1'b1;
        end
      end
      if (flame_done) begin
        check("done_expected", int'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          check("done_cycle", cyc, d);
        end
      end
      @(posedge clk);
      map_rdata <= rd_hit ? rd_val : 3'd7;
    end
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y, output int n);
    check("ev_ready_before_send", int'(ev_ready), 1);
    ev_valid = 1'b1; ev_x = x; ev_y = y;
    @(posedge clk); #1;
    n = cyc;
    ev_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_acc.size() == 0 && exp_done.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({"drain_", name}, int'(ok), 1);
  endtask

  task automatic check_quiet(input string name, input bit ovf);
    check({name, "_ev_ready"},   int'(ev_ready), 1);
    check({name, "_map_req"},    int'(map_req), 0);
    check({name, "_map_we"},     int'(map_we), 0);
    check({name, "_map_addr"},   int'(map_addr), 0);
    check({name, "_map_wdata"},  int'(map_wdata), 0);
    check({name, "_busy"},       int'(busy), 0);
    check({name, "_flame_done"}, int'(flame_done), 0);
    check({name, "_overflow"},   int'(overflow), int'(ovf));
  endtask

  int n;
  logic [9:0] bx [5];
  logic [9:0] by [5];

  initial begin
    fork
      run_monitor();
    join_none
    clear_map();

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset", 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_quiet("after_reset", 1'b0);

    // Open field, event (160,160) -> tile (10,10), centre 410
    send(10'd160, 10'd160, n);
    cross_160();
    exp_done.push_back(n + 27);
    wait_idle("open", 200);

    // WALL at (11,10), SOFT at (9,10): R 2 cycles, L 3, D/U 6 each
    clear_map();
    tmap[411] = 3'd1;
    tmap[409] = 3'd2;
    send(10'd160, 10'd160, n);
    acc(1'b1, 410);
    acc(1'b0, 411);
    acc(1'b0, 409); acc(1'b1, 409);
    arm2(450, 490); arm2(370, 330);
    exp_done.push_back(n + 20);
    wait_idle("wall_soft", 200);

    // Top-left corner: L and U arms leave the map immediately
    clear_map();
    send(10'd0, 10'd0, n);
    acc(1'b1, 0);
    arm2(1, 2); arm2(40, 80);
    exp_done.push_back(n + 15);
    wait_idle("corner_tl", 200);

    // Bottom-right corner (39,29): R and D arms leave the map
    send(10'd624, 10'd464, n);
    acc(1'b1, 1199);
    arm2(1198, 1197); arm2(1159, 1119);
    exp_done.push_back(n + 15);
    wait_idle("corner_br", 200);

    // Grant withheld for 5 cycles on the first read
    clear_map();
    send(10'd160, 10'd160, n);
    cross_160();
    exp_done.push_back(n + 32);
    wait_until(n + 3);
    map_gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("stall_req", int'(map_req), 1);
      check("stall_we", int'(map_we), 0);
      check("stall_addr", int'(map_addr), 411);
      if (i < 5) begin @(posedge clk); #1; end
    end
    map_gnt = 1'b1;
    wait_idle("stall", 200);

    // BOMB at (12,10)
    clear_map();
    tmap[412] = 3'd3;
    send(10'd160, 10'd160, n);
    acc(1'b1, 410);
    acc(1'b0, 411); acc(1'b1, 411); acc(1'b0, 412);
    arm2(409, 408); arm2(450, 490); arm2(370, 330);
    exp_done.push_back(n + 26);
`ifdef CHAIN_REACTION_EN
    acc(1'b1, 412);
    arm2(413, 414); arm2(411, 410); arm2(452, 492); arm2(372, 332);
    exp_done.push_back(n + 53);
`endif
    wait_idle("bomb", 300);
    check("bomb_overflow", int'(overflow), 0);

    // Burst of five while busy: four out-of-map events fill the FIFO,
    // the fifth is refused and sets overflow.
    clear_map();
    bx[0] = 10'd640;  by[0] = 10'd0;
    bx[1] = 10'd0;    by[1] = 10'd480;
    bx[2] = 10'd1023; by[2] = 10'd1023;
    bx[3] = 10'd640;  by[3] = 10'd480;
    bx[4] = 10'd0;    by[4] = 10'd0;
    send(10'd160, 10'd160, n);
    cross_160();
    exp_done.push_back(n + 27);
    exp_done.push_back(n + 29);
    exp_done.push_back(n + 31);
    exp_done.push_back(n + 33);
    exp_done.push_back(n + 35);
    wait_until(n + 4);
    for (int i = 0; i < 5; i++) begin
      check("burst_ev_ready", int'(ev_ready), (i < 4) ? 1 : 0);
      ev_valid = 1'b1; ev_x = bx[i]; ev_y = by[i];
      @(posedge clk); #1;
    end
    ev_valid = 1'b0;
    check("burst_overflow", int'(overflow), 1);
    check("burst_busy", int'(busy), 1);
    wait_idle("burst", 300);
    check("burst_overflow_sticky", int'(overflow), 1);

    // Reset in the middle of the R arm
    clear_map();
    send(10'd160, 10'd160, n);
    acc(1'b1, 410);
    acc(1'b0, 411); acc(1'b1, 411); acc(1'b0, 412);
    wait_until(n + 6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_quiet("mid_reset", 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("mid_reset_leftover_acc", exp_acc.size(), 0);
    check("mid_reset_busy_later", int'(busy), 0);
    check("mid_reset_partial_flame", int'(tmap[411]), 4);
    wait_idle("mid_reset", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
